led_pattern_sequencer: RTL and testbench

Pattern controller for the green LED bank: it turns the four pushbuttons into press events and schedules periodic ticks from the 50 MHz board clock. A small state machine uses these to decide when, and in which direction, an 8-bit pattern in LEDG[7:0] advances, blinks, pauses or clears. LEDG[8] is a heartbeat that toggles on every tick. The block replaces free-running counter bits as the LED timing source and sits directly between the board pins and the LEDs.

---
 rtl/led_seq_pkg.sv | 32 +++
 rtl/led_pattern_sequencer_key_press.sv | 38 +++
 rtl/led_pattern_sequencer.sv | 125 ++++++++++++
 tb/tb_led_pattern_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED pattern sequencer: FSM states, key roles
// and synchroniser depth.
package led_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEFT  = 3'd1,
        ST_RIGHT = 3'd2,
        ST_BLINK = 3'd3,
        ST_PAUSE = 3'd4
    } state_e;

    localparam int unsigned K_RUN       = 0;
    localparam int unsigned K_DIR       = 1;
    localparam int unsigned K_BLINK     = 2;
    localparam int unsigned K_STOP      = 3;
    localparam int unsigned NUM_KEYS    = 4;
    localparam int unsigned SYNC_STAGES = 3;
    localparam int unsigned PRESC_W     = 28;

    // Saved run state is kept as the low two bits of the run-state encoding.
    localparam logic [1:0] SAVED_LEFT = 2'd1;

    function automatic state_e resume_state(input logic [1:0] saved);
        case (saved)
            2'd2:    return ST_RIGHT;
            2'd3:    return ST_BLINK;
            default: return ST_LEFT;
        endcase
    endfunction

endpackage

// File: rtl/led_pattern_sequencer_key_press.sv
// One pushbutton: synchronise the inverted active-low key and emit a registered
// single-cycle pulse on each press (releases ignored).
module key_press
    import led_seq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   last_q, last_d;
    logic                   press_q, press_d;

    // Rise is seen between the last sync stage and its delayed copy; the pulse
    // itself is registered so KEY never reaches downstream logic combinationally.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], ~key_n};
        last_d  = sync_q[SYNC_STAGES-1];
        press_d = sync_q[SYNC_STAGES-1] & ~last_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            last_q  <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            last_q  <= last_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/led_pattern_sequencer.sv
// Green LED bank controller: key presses drive a run/pause/direction/blink FSM,
// a prescaler tick advances the 8-bit pattern and toggles the heartbeat LED.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned TICK_DIV = 12_500_000,
    parameter logic [7:0]  SEED     = 8'h01
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic [3:0] KEY,
    output logic [8:0] LEDG,
    output logic [2:0] STATE
);

    localparam logic [PRESC_W-1:0] TICK_LAST = PRESC_W'(TICK_DIV - 1);

    logic [NUM_KEYS-1:0] press;

    generate
        for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
            key_press u_key_press (
                .clk   (CLOCK_50),
                .rst   (RESET),
                .key_n (KEY[i]),
                .press (press[i])
            );
        end
    endgenerate

    logic [PRESC_W-1:0] cnt_q, cnt_d;
    logic               tick;
    logic               hb_q, hb_d;
    state_e             state_q, state_d;
    logic [1:0]         saved_q, saved_d;
    logic [7:0]         pat_q, pat_d;
    logic               acted;

    always_comb begin
        tick  = (cnt_q == TICK_LAST);
        cnt_d = tick ? '0 : cnt_q + PRESC_W'(1);
        hb_d  = hb_q ^ tick;
    end

    // Only the highest-priority pulse is considered; a press that changes
    // anything suppresses the pattern update of a coincident tick.
    always_comb begin
        state_d = state_q;
        saved_d = saved_q;
        pat_d   = pat_q;
        acted   = 1'b0;

        if (press[K_STOP]) begin
            state_d = ST_IDLE;
            pat_d   = '0;
            acted   = 1'b1;
        end else if (press[K_RUN]) begin
            acted = 1'b1;
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_LEFT;
                    pat_d   = SEED;
                end
                ST_PAUSE: state_d = resume_state(saved_q);
                default: begin
                    state_d = ST_PAUSE;
                    saved_d = state_q[1:0];
                end
            endcase
        end else if (press[K_DIR]) begin
            case (state_q)
                ST_LEFT: begin
                    state_d = ST_RIGHT;
                    acted   = 1'b1;
                end
                ST_RIGHT: begin
                    state_d = ST_LEFT;
                    acted   = 1'b1;
                end
                default: ;
            endcase
        end else if (press[K_BLINK]) begin
            case (state_q)
                ST_LEFT, ST_RIGHT: begin
                    state_d = ST_BLINK;
                    acted   = 1'b1;
                end
                ST_BLINK: begin
                    state_d = ST_LEFT;
                    acted   = 1'b1;
                end
                default: ;
            endcase
        end

        if (tick && !acted) begin
            case (state_q)
                ST_LEFT:  pat_d = {pat_q[6:0], pat_q[7]};
                ST_RIGHT: pat_d = {pat_q[0], pat_q[7:1]};
                ST_BLINK: pat_d = ~pat_q;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            cnt_q   <= '0;
            hb_q    <= 1'b0;
            state_q <= ST_IDLE;
            saved_q <= SAVED_LEFT;
            pat_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            hb_q    <= hb_d;
            state_q <= state_d;
            saved_q <= saved_d;
            pat_q   <= pat_d;
        end
    end

    assign LEDG  = {hb_q, pat_q};
    assign STATE = state_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer: directed table of press/tick
// steps, hand-written corner sequences and random keys against a reference model.
module tb_led_pattern_sequencer;

    localparam int TICK_DIV = 4;
    localparam int SEED     = 8'h01;
    localparam int OP_TICK  = 0;
    localparam int OP_PRESS = 1;

    logic       clk;
    logic       RESET;
    logic [3:0] KEY;
    logic [8:0] LEDG;
    logic [2:0] STATE;

    int checks = 0;
    int passed = 0;

    led_pattern_sequencer #(
        .TICK_DIV (TICK_DIV),
        .SEED     (8'(SEED))
    ) dut (
        .CLOCK_50 (clk),
        .RESET    (RESET),
        .KEY      (KEY),
        .LEDG     (LEDG),
        .STATE    (STATE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a press takes effect 4 edges after the first edge that
    // samples the key low; ticks fall on every TICK_DIV-th edge after reset.
    bit [3:0] hist [6];
    int m_n, m_state, m_saved, m_pat, m_hb;

    always @(posedge clk) begin
        bit [3:0] pr;
        bit       tk;
        bit       acted;
        if (RESET) begin
            for (int k = 0; k < 6; k++) hist[k] = 4'b0;
            m_n = 0; m_state = 0; m_saved = 1; m_pat = 0; m_hb = 0;
        end else begin
            pr = hist[3] & ~hist[4];
            tk = (m_n % TICK_DIV) == TICK_DIV - 1;
            m_n++;
            acted = 0;
            if (pr[3]) begin
                m_state = 0; m_pat = 0; acted = 1;
            end else if (pr[0]) begin
                acted = 1;
                if (m_state == 0) begin m_state = 1; m_pat = SEED; end
                else if (m_state == 4) m_state = m_saved;
                else begin m_saved = m_state; m_state = 4; end
            end else if (pr[1]) begin
                if (m_state == 1 || m_state == 2) begin m_state = 3 - m_state; acted = 1; end
            end else if (pr[2]) begin
                if (m_state == 1 || m_state == 2) begin m_state = 3; acted = 1; end
                else if (m_state == 3) begin m_state = 1; acted = 1; end
            end
            if (tk) m_hb = 1 - m_hb;
            if (tk && !acted) begin
                if (m_state == 1)      m_pat = (m_pat * 2) % 256 + m_pat / 128;
                else if (m_state == 2) m_pat = m_pat / 2 + (m_pat % 2) * 128;
                else if (m_state == 3) m_pat = 255 - m_pat;
            end
            for (int k = 5; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = ~KEY;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check("model_ledg", 32'(LEDG), 32'(m_hb * 256 + m_pat));
        check("model_state", 32'(STATE), 32'(m_state));
    endtask

    typedef struct {
        int         op;
        logic [3:0] mask;
        int         n;
        int         st;
        int         pat;
    } vec_t;

    vec_t vecs [20];

    initial begin
        int   prev;
        int   t;
        logic [3:0] kd;

        // Each row starts just before a tick edge; a press row samples its key on
        // that tick edge, so the old state advances once before the press lands.
        vecs[0]  = '{OP_PRESS, 4'b0001, 1,  1, 8'h01};
        vecs[1]  = '{OP_TICK,  4'b0000, 1,  1, 8'h02};
        vecs[2]  = '{OP_TICK,  4'b0000, 1,  1, 8'h04};
        vecs[3]  = '{OP_TICK,  4'b0000, 1,  1, 8'h08};
        vecs[4]  = '{OP_TICK,  4'b0000, 5,  1, 8'h01};
        vecs[5]  = '{OP_TICK,  4'b0000, 7,  1, 8'h80};
        vecs[6]  = '{OP_PRESS, 4'b0010, 1,  2, 8'h01};
        vecs[7]  = '{OP_TICK,  4'b0000, 1,  2, 8'h80};
        vecs[8]  = '{OP_PRESS, 4'b0100, 1,  3, 8'h40};
        vecs[9]  = '{OP_TICK,  4'b0000, 1,  3, 8'hBF};
        vecs[10] = '{OP_TICK,  4'b0000, 1,  3, 8'h40};
        vecs[11] = '{OP_PRESS, 4'b0001, 1,  4, 8'hBF};
        vecs[12] = '{OP_TICK,  4'b0000, 3,  4, 8'hBF};
        vecs[13] = '{OP_PRESS, 4'b0001, 1,  3, 8'hBF};
        vecs[14] = '{OP_TICK,  4'b0000, 1,  3, 8'h40};
        vecs[15] = '{OP_PRESS, 4'b0100, 1,  1, 8'hBF};
        vecs[16] = '{OP_PRESS, 4'b1001, 1,  0, 8'h00};
        vecs[17] = '{OP_PRESS, 4'b0001, 1,  1, 8'h01};
        vecs[18] = '{OP_PRESS, 4'b0010, 50, 2, 8'h20};
        vecs[19] = '{OP_PRESS, 4'b0100, 1,  3, 8'h10};

        KEY   = 4'hF;
        RESET = 1'b1;
        repeat (2) step();
        check("reset_ledg", 32'(LEDG), 32'h0);
        check("reset_state", 32'(STATE), 32'h0);
        RESET = 1'b0;

        for (int j = 1; j <= 20; j++) begin
            step();
            check("idle_pattern", 32'(LEDG[7:0]), 32'h0);
            check("idle_heartbeat", 32'(LEDG[8]), 32'((j / 4) % 2));
            check("idle_state", 32'(STATE), 32'h0);
        end
        repeat (3) step();

        prev = 0;
        for (int i = 0; i < 20; i++) begin
            if (vecs[i].op == OP_TICK) begin
                repeat (4 * vecs[i].n) step();
                check($sformatf("row%0d_state", i), 32'(STATE), 32'(vecs[i].st));
            end else begin
                t = 4 * ((vecs[i].n + 3) / 4) + 4;
                for (int e = 0; e < t; e++) begin
                    KEY = (e < vecs[i].n) ? ~vecs[i].mask : 4'hF;
                    step();
                    if (e < 4)
                        check($sformatf("row%0d_before_edge%0d", i, e), 32'(STATE), 32'(prev));
                    else
                        check($sformatf("row%0d_after_edge%0d", i, e), 32'(STATE), 32'(vecs[i].st));
                end
                KEY = 4'hF;
            end
            check($sformatf("row%0d_pattern", i), 32'(LEDG[7:0]), 32'(vecs[i].pat));
            prev = vecs[i].st;
        end

        // Reset in BLINK on the very edge a pending KEY0 press would land.
        KEY = 4'b1110;
        step();
        KEY = 4'hF;
        repeat (3) step();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        check("midrun_reset_ledg", 32'(LEDG), 32'h0);
        check("midrun_reset_state", 32'(STATE), 32'h0);
        repeat (4) step();
        check("post_reset_state", 32'(STATE), 32'h0);
        check("post_reset_first_tick", 32'(LEDG), 32'h100);

        kd = 4'hF;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 4; k++)
                if ($urandom_range(0, 5) == 0) kd[k] = ~kd[k];
            KEY   = kd;
            RESET = ($urandom_range(0, 399) == 0);
            step();
        end
        RESET = 1'b0;
        KEY   = 4'hF;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
